disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Scan controller for the four-digit seven-segment display. It owns the shared `timer` instance: it programs `tmr_period` for each display phase and advances on every `flag` pulse. Each digit is cycled through a lit ON phase and a dark BLANK phase, which suppresses ghosting and sets brightness. The block sits between the value registers and the board's anode/segment pins.

## Interface

**Parameters**
- `ON_PERIOD`, 24'h000800: `tmr_period` value driven during every ON phase.
- `BLANK_PERIOD`, 24'h000100: base `tmr_period` value for BLANK phases, before brightness scaling.

**Ports**
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flag` input 1: one-cycle expiry pulse from `timer`.
- `value` input 16: four hex digits; digit k = `value[4k+3:4k]`.
- `dp_in` input 4: decimal point request per digit, 1 = lit.
- `dig_en` input 4: per-digit enable, 1 = digit may light.
- `brightness` input 2: 3 = brightest, 0 = dimmest.
- `tmr_period` output 24: period programmed into `timer`.
- `an` output 4: anode drives, active-low, one-hot-low during ON.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` output 1: decimal point, active-low.
- `frame_tick` output 1: one-cycle pulse at end of each frame.

## Operation

- State is {phase ∈ ON, BLANK; idx ∈ 0..3}. `flag` is the only event that advances state. Any `flag` pulse ends the current phase.
- **ON idx, on `flag`:** go to BLANK idx.
  - `tmr_period` = blank value.
  - `an` = 4'hF, `seg` = 7'h7F, `dp` = 1.
- **BLANK idx, on `flag`:** go to ON (idx+1) mod 4.
  - `tmr_period` = `ON_PERIOD`.
  - `an` bit idx+1 low, all others high.
  - `seg` and `dp` come from the latched data for that digit.
- **Frame latch:** leaving BLANK 3 (entering ON 0):
  - latch `value`, `dp_in` and `dig_en` into shadow registers used for the whole frame (no tearing);
  - pulse `frame_tick` for one cycle.
- **Disabled digit** (shadow `dig_en[k]` = 0): its ON phase is still timed with `ON_PERIOD`, but `an` = 4'hF, `seg` = 7'h7F, `dp` = 1. Frame rate does not depend on `dig_en`.
- **Blank value:** `BLANK_PERIOD << (3 - brightness)`, computed in 27 bits and saturated to 24'hFFFFFF if bits 26:24 are nonzero. `brightness` is sampled on the `flag` that enters BLANK and held for that phase.
- **Hex decode (active-low):**
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30
  - 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78
  - 8 = 7'h00, 9 = 7'h10, A = 7'h08, b = 7'h03
  - C = 7'h46, d = 7'h21, E = 7'h06, F = 7'h0E
- `dp` = ~shadow `dp_in[idx]` during an enabled ON phase, else 1.

## Timing

- **All outputs registered.** A `flag` sampled in cycle N updates outputs in cycle N+1.
- **`tmr_period`** changes only in the cycle after a `flag`, and is stable for the whole phase.
- **Reset values:**
  - state = BLANK 3
  - `tmr_period` = `BLANK_PERIOD` (brightness scaling not applied)
  - `an` = 4'hF, `seg` = 7'h7F, `dp` = 1, `frame_tick` = 0
  - shadow registers = 0
- **First `flag` after reset:** enters ON 0, latches inputs and pulses `frame_tick`.
- **`rst` and `flag` in the same cycle:** `rst` wins and the `flag` is discarded.
- **`rst` mid-phase:** returns to the reset values in the next cycle with no partial output.
- **`flag` on consecutive cycles:** each pulse advances exactly one phase; none are lost.
- **Input changes mid-frame:** changes to `value`, `dp_in` and `dig_en` have no visible effect until the next frame latch.

## Test plan

- **Reset:** hold `rst` = 1 for 3 cycles. Then `an` = F, `seg` = 7F, `dp` = 1, `tmr_period` = 000100, `frame_tick` = 0.
- **Full frame:** `value` = 16'h1A80, `dp_in` = 4'b0100, `dig_en` = F, `brightness` = 3, eight `flag` pulses. Outputs in order:
  - `an` E / `seg` 40, blank, `an` D / `seg` 00, blank
  - `an` B / `seg` 08 / `dp` 0, blank, `an` 7 / `seg` 79, blank
  - `frame_tick` is high exactly once, after the first `flag`.
- **Period sequencing:** with `brightness` = 3, `tmr_period` alternates 000800 / 000100. With `brightness` = 0, the blank value is 000800. With `BLANK_PERIOD` = 24'h400000 and `brightness` = 0, it saturates to FFFFFF.
- **Disabled digits and tearing:** `dig_en` = 4'b0101. Change `value` during ON 1.
  - Digits 1 and 3 stay dark and the ON timing is unchanged.
  - The new `value` first appears on ON 0 of the next frame.
- **Collision:** assert `rst` and `flag` in the same cycle during ON 2. Next cycle shows the reset values. The next `flag` enters ON 0.
- **Back-to-back:** `flag` high on 4 consecutive cycles from BLANK 3. State ends in BLANK 1 with `an` = F, and `frame_tick` pulses once.

Source files
------------

// File: rtl/disp_scan_ctrl_if.sv
// Bus between the value registers / shared timer and the display scan controller.
interface disp_scan_ctrl_if;
  logic        flag;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  dig_en;
  logic [1:0]  brightness;
  logic [23:0] tmr_period;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  modport master (
    output flag, value, dp_in, dig_en, brightness,
    input  tmr_period, an, seg, dp, frame_tick
  );

  modport slave (
    input  flag, value, dp_in, dig_en, brightness,
    output tmr_period, an, seg, dp, frame_tick
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller: alternates lit ON and dark BLANK
// phases per digit, paced by the shared timer's flag pulses.
module disp_scan_ctrl #(
  parameter logic [23:0] ON_PERIOD    = 24'h000800,
  parameter logic [23:0] BLANK_PERIOD = 24'h000100
) (
  input logic             clk,
  input logic             rst,
  disp_scan_ctrl_if.slave bus
);

  typedef enum logic {PH_ON, PH_BLANK} phase_e;

  phase_e      phase_q, phase_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] val_q, val_d;
  logic [3:0]  dpin_q, dpin_d;
  logic [3:0]  en_q, en_d;
  logic [23:0] tmr_q, tmr_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        ft_q, ft_d;

  logic [26:0] blank_ext;
  logic [23:0] blank_val;
  logic [15:0] val_src;
  logic [3:0]  dpin_src;
  logic [3:0]  en_src;
  logic [3:0]  nibble;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    blank_ext = {3'b000, BLANK_PERIOD} << (2'd3 - bus.brightness);
    blank_val = (blank_ext[26:24] != 3'b000) ? '1 : blank_ext[23:0];
  end

  always_comb begin
    phase_d  = phase_q;
    idx_d    = idx_q;
    val_d    = val_q;
    dpin_d   = dpin_q;
    en_d     = en_q;
    tmr_d    = tmr_q;
    an_d     = an_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    ft_d     = 1'b0;
    // Leaving BLANK 3 uses the freshly latched frame data directly, not the old shadow.
    val_src  = (idx_q == 2'd3) ? bus.value  : val_q;
    dpin_src = (idx_q == 2'd3) ? bus.dp_in  : dpin_q;
    en_src   = (idx_q == 2'd3) ? bus.dig_en : en_q;
    nibble   = val_src[{idx_q + 2'd1, 2'b00} +: 4];

    if (bus.flag) begin
      if (phase_q == PH_ON) begin
        phase_d = PH_BLANK;
        tmr_d   = blank_val;
        an_d    = '1;
        seg_d   = '1;
        dp_d    = 1'b1;
      end else begin
        phase_d = PH_ON;
        idx_d   = idx_q + 2'd1;
        tmr_d   = ON_PERIOD;
        if (idx_q == 2'd3) begin
          val_d  = bus.value;
          dpin_d = bus.dp_in;
          en_d   = bus.dig_en;
          ft_d   = 1'b1;
        end
        if (en_src[idx_d]) begin
          an_d  = ~(4'b0001 << idx_d);
          seg_d = hex7(nibble);
          dp_d  = ~dpin_src[idx_d];
        end else begin
          an_d  = '1;
          seg_d = '1;
          dp_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_BLANK;
      idx_q   <= 2'd3;
      val_q   <= '0;
      dpin_q  <= '0;
      en_q    <= '0;
      tmr_q   <= BLANK_PERIOD;
      an_q    <= '1;
      seg_q   <= '1;
      dp_q    <= 1'b1;
      ft_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dpin_q  <= dpin_d;
      en_q    <= en_d;
      tmr_q   <= tmr_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      ft_q    <= ft_d;
    end
  end

  assign bus.tmr_period = tmr_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: behavioural model compared every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_disp_scan_ctrl;

  localparam logic [23:0] ONP  = 24'h000800;
  localparam logic [23:0] BP1  = 24'h000100;
  localparam logic [23:0] BP2  = 24'h400000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_scan_ctrl_if bus1 ();
  disp_scan_ctrl_if bus2 ();

  assign bus2.flag       = bus1.flag;
  assign bus2.value      = bus1.value;
  assign bus2.dp_in      = bus1.dp_in;
  assign bus2.dig_en     = bus1.dig_en;
  assign bus2.brightness = bus1.brightness;

  disp_scan_ctrl #(.ON_PERIOD(ONP), .BLANK_PERIOD(BP1)) dut (.clk(clk), .rst(rst), .bus(bus1.slave));
  disp_scan_ctrl #(.ON_PERIOD(ONP), .BLANK_PERIOD(BP2)) dut_sat (.clk(clk), .rst(rst), .bus(bus2.slave));

  int errors = 0;
  int checks = 0;

  // Segment table, active-low {g,f,e,d,c,b,a}
  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Behavioural model
  bit          chk_en = 0;
  bit          m_on;
  int          m_idx;
  logic [15:0] s_val;
  logic [3:0]  s_dp, s_en;
  logic [23:0] m_tmr, m_tmr2;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp, m_ft;

  function automatic logic [23:0] blank_of(input logic [23:0] base, input logic [1:0] b);
    longint v;
    v = longint'(base) * (longint'(1) << (3 - int'(b)));
    if (v > 64'hFFFFFF) return 24'hFFFFFF;
    return v[23:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on = 0; m_idx = 3; s_val = '0; s_dp = '0; s_en = '0;
      m_tmr = BP1; m_tmr2 = BP2; m_an = 4'hF; m_seg = 7'h7F; m_dp = 1; m_ft = 0;
      chk_en = 1;
    end else begin
      m_ft = 0;
      if (bus1.flag) begin
        if (m_on) begin
          m_on = 0;
          m_tmr  = blank_of(BP1, bus1.brightness);
          m_tmr2 = blank_of(BP2, bus1.brightness);
          m_an = 4'hF; m_seg = 7'h7F; m_dp = 1;
        end else begin
          m_on = 1;
          m_idx = (m_idx + 1) % 4;
          if (m_idx == 0) begin
            s_val = bus1.value; s_dp = bus1.dp_in; s_en = bus1.dig_en; m_ft = 1;
          end
          m_tmr = ONP; m_tmr2 = ONP;
          if (s_en[m_idx]) begin
            m_an  = 4'hF & ~(4'(1) << m_idx);
            m_seg = HEX[(s_val >> (4 * m_idx)) & 16'hF];
            m_dp  = ~s_dp[m_idx];
          end else begin
            m_an = 4'hF; m_seg = 7'h7F; m_dp = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (bus1.an !== m_an || bus1.seg !== m_seg || bus1.dp !== m_dp ||
          bus1.frame_tick !== m_ft || bus1.tmr_period !== m_tmr || bus2.tmr_period !== m_tmr2) begin
        errors++;
        $display("FAIL model t=%0t: got an=%h seg=%h dp=%b ft=%b tmr=%h tmr2=%h expected an=%h seg=%h dp=%b ft=%b tmr=%h tmr2=%h",
                 $time, bus1.an, bus1.seg, bus1.dp, bus1.frame_tick, bus1.tmr_period, bus2.tmr_period,
                 m_an, m_seg, m_dp, m_ft, m_tmr, m_tmr2);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input int gap);
    bus1.flag = 1'b1;
    cyc();
    bus1.flag = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  logic [3:0] exp_an  [8] = '{4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF};
  logic [6:0] exp_seg [8] = '{7'h40, 7'h7F, 7'h00, 7'h7F, 7'h08, 7'h7F, 7'h79, 7'h7F};
  logic       exp_dp  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int ft_cnt;
    rst = 1'b1;
    bus1.flag = 1'b0; bus1.value = '0; bus1.dp_in = '0; bus1.dig_en = '0; bus1.brightness = 2'd3;
    @(negedge clk);
    idle(3);
    rst = 1'b0;
    chk("reset_an", 32'(bus1.an), 32'hF);
    chk("reset_seg", 32'(bus1.seg), 32'h7F);
    chk("reset_dp", 32'(bus1.dp), 32'h1);
    chk("reset_tmr", 32'(bus1.tmr_period), 32'h000100);
    chk("reset_ft", 32'(bus1.frame_tick), 32'h0);
    idle(2);

    // Full frame
    bus1.value = 16'h1A80; bus1.dp_in = 4'b0100; bus1.dig_en = 4'hF; bus1.brightness = 2'd3;
    ft_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      pulse(0);
      chk($sformatf("frame_an%0d", i), 32'(bus1.an), 32'(exp_an[i]));
      chk($sformatf("frame_seg%0d", i), 32'(bus1.seg), 32'(exp_seg[i]));
      chk($sformatf("frame_dp%0d", i), 32'(bus1.dp), 32'(exp_dp[i]));
      chk($sformatf("frame_tmr%0d", i), 32'(bus1.tmr_period), (i % 2 == 0) ? 32'h800 : 32'h100);
      if (bus1.frame_tick) ft_cnt++;
      idle(1 + i % 2);
    end
    chk("frame_tick_count", 32'(ft_cnt), 32'd1);

    // Dimmest brightness, plus saturation in the large-base instance
    pulse(0);
    bus1.brightness = 2'd0;
    pulse(0);
    chk("blank_dim", 32'(bus1.tmr_period), 32'h000800);
    chk("blank_sat", 32'(bus2.tmr_period), 32'hFFFFFF);
    idle(1);
    bus1.brightness = 2'd3;
    for (int i = 0; i < 6; i++) begin pulse(0); idle(1); end

    // Disabled digits and tearing
    bus1.value = 16'h1234; bus1.dig_en = 4'b0101; bus1.dp_in = 4'b0000;
    pulse(0);
    chk("dis_on0_an", 32'(bus1.an), 32'hE);
    chk("dis_on0_seg", 32'(bus1.seg), 32'h19);
    pulse(0); pulse(0);
    chk("dis_on1_an", 32'(bus1.an), 32'hF);
    chk("dis_on1_seg", 32'(bus1.seg), 32'h7F);
    chk("dis_on1_tmr", 32'(bus1.tmr_period), 32'h800);
    bus1.value = 16'h5678; bus1.dig_en = 4'hF;
    idle(2);
    pulse(0); pulse(0);
    chk("tear_on2_seg", 32'(bus1.seg), 32'h24);
    chk("tear_on2_an", 32'(bus1.an), 32'hB);
    pulse(0); pulse(0);
    chk("dis_on3_an", 32'(bus1.an), 32'hF);
    pulse(0); pulse(0);
    chk("tear_next_on0_seg", 32'(bus1.seg), 32'h00);
    chk("tear_next_on0_an", 32'(bus1.an), 32'hE);

    // Collision during ON 2
    for (int i = 0; i < 4; i++) pulse(0);
    chk("coll_on2_an", 32'(bus1.an), 32'hB);
    rst = 1'b1; bus1.flag = 1'b1;
    cyc();
    rst = 1'b0; bus1.flag = 1'b0;
    chk("coll_an", 32'(bus1.an), 32'hF);
    chk("coll_tmr", 32'(bus1.tmr_period), 32'h000100);
    idle(1);
    pulse(0);
    chk("coll_next_an", 32'(bus1.an), 32'hE);
    chk("coll_next_ft", 32'(bus1.frame_tick), 32'h1);

    // Back-to-back flags from BLANK 3
    for (int i = 0; i < 7; i++) pulse(0);
    idle(1);
    ft_cnt = 0;
    bus1.flag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus1.frame_tick) ft_cnt++;
    end
    bus1.flag = 1'b0;
    chk("b2b_an", 32'(bus1.an), 32'hF);
    cyc();
    if (bus1.frame_tick) ft_cnt++;
    chk("b2b_ft_count", 32'(ft_cnt), 32'd1);
    pulse(0);
    chk("b2b_next_an", 32'(bus1.an), 32'hB);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus1.flag = ($urandom_range(0, 9) < 4);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 4) == 0) bus1.value = 16'($urandom);
      if ($urandom_range(0, 9) == 0) bus1.dp_in = 4'($urandom);
      if ($urandom_range(0, 9) == 0) bus1.dig_en = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus1.brightness = 2'($urandom);
      cyc();
    end
    rst = 1'b0; bus1.flag = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
